// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-seg display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  dec_d,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LIT  = DIV_W'(2);
  localparam logic [1:0]       IDX_LAST = 2'(DIGITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_buf_q, pend_buf_d;
  logic             pending_q, pending_d;
  logic [3:0]       dec_d_q, dec_d_d;
  logic [3:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  logic tc;
  logic bnd;
  logic show;

  assign tc  = (div_q == DIV_LAST);
  assign bnd = tc && (idx_q == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] hi;
  always_comb begin
    hi = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (shadow_q[4*i +: 4] != 4'd0) hi = 2'(i);
    end
    show = (idx_q <= hi);
  end
`else
  assign show = 1'b1;
`endif

  always_comb begin
    div_d        = tc ? '0 : div_q + 1'b1;
    idx_d        = tc ? idx_q + 2'd1 : idx_q;
    frame_tick_d = bnd;
    dec_d_d      = shadow_q[{idx_q, 2'b00} +: 4];
    shadow_d     = shadow_q;
    pend_buf_d   = pend_buf_q;
    pending_d    = pending_q;
    an_d         = 4'b1111;
    // anodes stay dark for two cycles after each digit switch
    if (enable && (div_q >= DIV_LIT) && show)
      an_d = ~(4'b0001 << idx_q);
    if (bnd) begin
      if (load) begin
        shadow_d  = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = pend_buf_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      pend_buf_d = value;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'd0;
      pend_buf_q   <= 16'd0;
      pending_q    <= 1'b0;
      dec_d_q      <= 4'd0;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      dec_d_q      <= dec_d_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dec_d      = dec_d_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=8.
// Expected outputs come from a cycle-count model of the display.
module tb_seg_scan_ctrl;

  localparam int RDIV  = 8;
  localparam int FRAME = 4 * RDIV;

  typedef struct packed {
    logic [3:0] dec;
    logic [3:0] an;
    logic       pend;
    logic       ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'd0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  dec_d;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  int          m_n = 0;
  logic [15:0] m_shadow = 16'd0;
  logic [15:0] m_pend = 16'd0;
  logic        m_pending = 1'b0;

  seg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(RDIV), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .enable(enable), .dec_d(dec_d), .an(an),
    .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    return 4'((v >> (4 * i)) & 16'hF);
  endfunction

  // Predict outputs after the coming edge from the cycle count since reset.
  function automatic exp_t predict(input logic r, input logic [15:0] v,
                                   input logic l, input logic e);
    exp_t x;
    int ph, dig, top;
    bit lit;
    if (!r) begin
      x = '{dec: 4'd0, an: 4'hF, pend: 1'b0, ft: 1'b0};
      m_n = 0; m_shadow = 16'd0; m_pend = 16'd0; m_pending = 1'b0;
      return x;
    end
    ph  = m_n % RDIV;
    dig = (m_n / RDIV) % 4;
    top = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 4; i++) if (nib(m_shadow, i) != 0) top = i;
`else
    top = 3;
`endif
    lit   = e && ph >= 2 && dig <= top;
    x.dec = nib(m_shadow, dig);
    x.an  = lit ? ~(4'b0001 << dig) : 4'hF;
    x.ft  = (m_n % FRAME) == FRAME - 1;
    if (x.ft) begin
      if (l) m_shadow = v;
      else if (m_pending) m_shadow = m_pend;
      m_pending = 1'b0;
    end else if (l) begin
      m_pend = v;
      m_pending = 1'b1;
    end
    x.pend = m_pending;
    m_n++;
    return x;
  endfunction

  task automatic step(input logic r, input logic [15:0] v,
                      input logic l, input logic e);
    rst_n = r; value = v; load = l; enable = e;
    q.push_back(predict(r, v, l, e));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b1);
  endtask

  task automatic run_to(input int ph);
    int g = 0;
    while ((m_n % FRAME) != ph && g < 200) begin
      run(1);
      g++;
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("dec_d", dec_d, x.dec);
        chk("an", an, x.an);
        chk("pending", pending, x.pend);
        chk("frame_tick", frame_tick, x.ft);
      end
    end
  end

  initial begin : driver
    int g;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 16'hFFFF, 1'b1, 1'b1);
    step(1'b1, 16'h1A2F, 1'b1, 1'b1);
    run(2 * FRAME);
    run_to(10);
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    run(5);
    step(1'b1, 16'h5678, 1'b1, 1'b1);
    run(FRAME + 8);
    run_to(FRAME - 1);
    step(1'b1, 16'hBEEF, 1'b1, 1'b1);
    run(FRAME);
    run_to(12);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 1'b0, 1'b0);
    run(FRAME + 4);
    step(1'b1, 16'h0042, 1'b1, 1'b1);
    run(2 * FRAME);
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    run(2 * FRAME);
    run_to(20);
    step(1'b1, 16'h9999, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    run(FRAME + 2);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) != 0, 16'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0);
    end
    g = 0;
    while (q.size() > 0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
